// File: rtl/fifo_reader.sv
// ----------------------------------------------------------------------------
// fifo_reader
//
// Burst-mode consumer for the 32-entry push/pull FIFO. It watches the FIFO's
// empty flag and first-word-fall-through head word, pops words with pull,
// stages them in a 2-entry output buffer and presents them on a valid/ready
// stream. One burst of burst_len words is transferred per start command.
// Per-burst progress (words_sent) and an XOR checksum of every word handed
// downstream are reported alongside.
//
// Parameters:
//   BUSW      data width, equal to the FIFO bus width
//   MAXBURST  largest legal burst length
//   CNTW      counter width, wide enough to hold MAXBURST
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset
//   start       one-cycle burst command, only honoured while idle
//   burst_len   words in the burst, sampled together with start
//   empty       FIFO empty flag
//   dataout     FIFO head word, valid whenever empty is low
//   pull        pop request to the FIFO (combinational)
//   out_valid   output buffer head is valid
//   out_ready   downstream accepts the head word
//   out_data    output buffer head word
//   out_last    head word is the final word of the burst
//   busy        a burst is in progress (state is not IDLE)
//   done        one-cycle pulse when a burst completes
//   words_sent  handshakes completed in the current or most recent burst
//   checksum    XOR of words handed off in the current or most recent burst
// ----------------------------------------------------------------------------
module fifo_reader #(
   parameter int BUSW     = 32,
   parameter int MAXBURST = 256,
   parameter int CNTW     = $clog2(MAXBURST + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [CNTW-1:0] burst_len,
   input  logic            empty,
   input  logic [BUSW-1:0] dataout,
   output logic            pull,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BUSW-1:0] out_data,
   output logic            out_last,
   output logic            busy,
   output logic            done,
   output logic [CNTW-1:0] words_sent,
   output logic [BUSW-1:0] checksum
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;

   // Burst bookkeeping: requested length and number of words popped so far.
   logic [CNTW-1:0] len;
   logic [CNTW-1:0] fetched;

   // Two-entry output buffer, managed as a tiny circular FIFO.
   logic [BUSW-1:0] buf_mem [2];
   logic            wr_ptr;
   logic            rd_ptr;
   logic [1:0]      buf_count;

   logic            accept;
   logic            handshake;
   logic            final_hs;

   // The buffer head drives the stream directly, so a word popped from the
   // FIFO on one edge is visible downstream in the very next cycle.
   assign out_valid = (buf_count != 2'd0);
   assign out_data  = buf_mem[rd_ptr];
   assign handshake = out_valid && out_ready;

   // The last word is identified by how many words have already left, not by
   // how many were fetched, so it stays correct while the buffer is stalled.
   assign out_last  = out_valid && (words_sent == len - CNTW'(1));
   assign final_hs  = handshake && out_last;

   // State register. Reset is asynchronous so a mid-burst reset abandons the
   // burst immediately rather than waiting for the next clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control outputs. pull looks only at empty, the current
   // buffer occupancy and the fetch count: it deliberately ignores a pop that
   // may happen in the same cycle, so pull never depends on out_ready and the
   // FIFO sees a request that changes only through its own registered flags.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      pull       = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               accept = 1'b1;
               if (burst_len != '0) begin
                  state_next = S_RUN;
               end else begin
                  state_next = S_DONE;
               end
            end
         end
         S_RUN: begin
            pull = !empty && (buf_count < 2'd2) && (fetched < len);
            if (final_hs) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = S_IDLE;
         end
      endcase
   end

   // Burst counters. An accepted start clears the progress counters and
   // latches the new length; between bursts words_sent and checksum hold so
   // software can read the result of the most recent burst at leisure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len        <= '0;
         fetched    <= '0;
         words_sent <= '0;
         checksum   <= '0;
      end else if (accept) begin
         len        <= burst_len;
         fetched    <= '0;
         words_sent <= '0;
         checksum   <= '0;
      end else begin
         if (pull) begin
            fetched <= fetched + CNTW'(1);
         end
         if (handshake) begin
            words_sent <= words_sent + CNTW'(1);
            checksum   <= checksum ^ out_data;
         end
      end
   end

   // Buffer pointers and occupancy. A simultaneous write and pop touch
   // different slots (the pointers differ whenever the buffer is non-empty
   // and not full), so ordering is preserved and the count stays put.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         buf_count <= 2'd0;
      end else begin
         if (pull) begin
            wr_ptr <= ~wr_ptr;
         end
         if (handshake) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({pull, handshake})
            2'b10:   buf_count <= buf_count + 2'd1;
            2'b01:   buf_count <= buf_count - 2'd1;
            default: buf_count <= buf_count;
         endcase
      end
   end

   // Buffer storage has no reset: the contents are only observed while
   // buf_count says the slot is occupied, and reset empties the buffer.
   always_ff @(posedge clk) begin
      if (pull) begin
         buf_mem[wr_ptr] <= dataout;
      end
   end

endmodule

// File: tb/tb_fifo_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_reader
//
// Directed bench for fifo_reader. A queue models the first-word-fall-through
// FIFO; words are assigned to a burst scoreboard as they become available and
// compared, in order, at every downstream handshake.
// ----------------------------------------------------------------------------
module tb_fifo_reader;

   localparam int BUSW     = 32;
   localparam int MAXBURST = 256;
   localparam int CNTW     = $clog2(MAXBURST + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [CNTW-1:0] burst_len;
   logic            empty;
   logic [BUSW-1:0] dataout;
   logic            pull;
   logic            out_valid;
   logic            out_ready;
   logic [BUSW-1:0] out_data;
   logic            out_last;
   logic            busy;
   logic            done;
   logic [CNTW-1:0] words_sent;
   logic [BUSW-1:0] checksum;

   typedef struct packed {
      logic [BUSW-1:0] data;
      logic            last;
   } exp_t;

   logic [BUSW-1:0] fifo_q [$];
   logic [BUSW-1:0] avail_q [$];
   exp_t            exp_q [$];
   int              hs_cyc_q [$];

   int              n_checks = 0;
   int              n_fail = 0;
   int              budget = 0;
   int              pop_count = 0;
   int              hs_count = 0;
   int              done_count = 0;
   int              done_base = 0;
   int              cyc = 0;
   int              exp_ws = 0;
   logic [BUSW-1:0] exp_cs = '0;
   logic            will_pop = 1'b0;
   logic            done_next = 1'b0;
   logic            zero_pending = 1'b0;

   fifo_reader #(
      .BUSW     (BUSW),
      .MAXBURST (MAXBURST),
      .CNTW     (CNTW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .burst_len  (burst_len),
      .empty      (empty),
      .dataout    (dataout),
      .pull       (pull),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done),
      .words_sent (words_sent),
      .checksum   (checksum)
   );

   // 10 ns clock; stimulus changes 2 ns after each rising edge.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic refreshFifo();
      empty   = (fifo_q.size() == 0);
      dataout = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   // Hand FIFO words to the active burst, marking the final one.
   task automatic assignWords();
      exp_t e;
      while (budget > 0 && avail_q.size() > 0) begin
         e.data = avail_q.pop_front();
         e.last = (budget == 1);
         exp_q.push_back(e);
         exp_cs = exp_cs ^ e.data;
         budget--;
      end
   endtask

   task automatic pushWord(input logic [BUSW-1:0] w);
      fifo_q.push_back(w);
      avail_q.push_back(w);
      assignWords();
      refreshFifo();
   endtask

   task automatic flushFifo();
      fifo_q.delete();
      avail_q.delete();
      refreshFifo();
   endtask

   task automatic applyStimulus(input logic s, input logic [CNTW-1:0] len, input logic rdy);
      @(posedge clk);
      #2;
      start     = s;
      burst_len = len;
      out_ready = rdy;
   endtask

   task automatic startBurst(input int n, input logic rdy);
      done_base = done_count;
      applyStimulus(1'b1, CNTW'(n), rdy);
      exp_cs = '0;
      exp_ws = n;
      if (n == 0) begin
         zero_pending = 1'b1;
      end else begin
         budget = n;
         assignWords();
      end
      applyStimulus(1'b0, '0, rdy);
   endtask

   task automatic runUntilDone(input int max_cycles, input logic alternate);
      for (int i = 0; i < max_cycles; i++) begin
         if (done_count > done_base) break;
         applyStimulus(1'b0, '0, alternate ? logic'(i % 2 == 0) : 1'b1);
      end
      checkOutput("done_seen", 64'(done_count > done_base), 64'(1));
      applyStimulus(1'b0, '0, 1'b1);
   endtask

   task automatic burstChecks(input string tag, input int pops);
      checkOutput({tag, "_words_sent"}, 64'(words_sent), 64'(exp_ws));
      checkOutput({tag, "_checksum"}, 64'(checksum), 64'(exp_cs));
      checkOutput({tag, "_scoreboard_drained"}, 64'(exp_q.size()), 64'(0));
      checkOutput({tag, "_pops"}, 64'(pops), 64'(exp_ws));
   endtask

   // FIFO model: a pull seen before the edge removes the head 1 ns later.
   always @(posedge clk) begin
      #1;
      if (will_pop) begin
         pop_count++;
         if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      refreshFifo();
   end

   // Output monitor, sampling mid-cycle while everything is stable.
   always @(negedge clk) begin
      exp_t e;
      logic dn;
      cyc++;
      will_pop = pull;
      dn = 1'b0;
      checkOutput("done_timing", 64'(done), 64'(done_next));
      if (done === 1'b1) done_count++;
      if (!rst) begin
         if (pull === 1'b1) checkOutput("pull_when_empty", 64'(empty), 64'(0));
         if (dut.buf_count == 2'd2) checkOutput("pull_when_full", 64'(pull), 64'(0));
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            hs_count++;
            hs_cyc_q.push_back(cyc);
            checkOutput("unexpected_word", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               checkOutput("out_data", 64'(out_data), 64'(e.data));
               checkOutput("out_last", 64'(out_last), 64'(e.last));
               dn = e.last;
            end
         end
         if (zero_pending && start === 1'b1) begin
            dn = 1'b1;
            zero_pending = 1'b0;
         end
      end
      done_next = dn;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int pop_base;
      int hs_base;

      rst       = 1'b1;
      start     = 1'b0;
      burst_len = '0;
      out_ready = 1'b0;
      refreshFifo();

      // Reset state.
      repeat (3) @(posedge clk);
      #2;
      checkOutput("rst_pull", 64'(pull), 64'(0));
      checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_done", 64'(done), 64'(0));
      checkOutput("rst_words_sent", 64'(words_sent), 64'(0));
      checkOutput("rst_checksum", 64'(checksum), 64'(0));
      rst = 1'b0;

      // Basic burst of four words with downstream always ready.
      $display("[TB] basic burst");
      applyStimulus(1'b0, '0, 1'b1);
      for (int i = 0; i < 4; i++) pushWord(BUSW'(32'h11 + i));
      pop_base = pop_count;
      hs_cyc_q.delete();
      startBurst(4, 1'b1);
      checkOutput("basic_busy", 64'(busy), 64'(1));
      runUntilDone(40, 1'b0);
      burstChecks("basic", pop_count - pop_base);
      checkOutput("basic_checksum_value", 64'(checksum), 64'(32'h0000_0004));
      checkOutput("basic_hs_count", 64'(hs_cyc_q.size()), 64'(4));
      checkOutput("basic_back_to_back", 64'(hs_cyc_q[3] - hs_cyc_q[0]), 64'(3));
      checkOutput("basic_fifo_empty", 64'(fifo_q.size()), 64'(0));
      checkOutput("basic_idle", 64'(busy), 64'(0));

      // Backpressure: out_ready toggles every cycle.
      $display("[TB] backpressure");
      for (int i = 0; i < 8; i++) pushWord($urandom);
      pop_base = pop_count;
      startBurst(8, 1'b1);
      runUntilDone(100, 1'b1);
      burstChecks("bp", pop_count - pop_base);
      checkOutput("bp_fifo_empty", 64'(fifo_q.size()), 64'(0));

      // Underflow gaps: one word every three cycles, more than requested.
      $display("[TB] underflow gaps");
      pop_base = pop_count;
      startBurst(5, 1'b1);
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1'b0, '0, 1'b1);
         pushWord(BUSW'(32'h300 + k));
         applyStimulus(1'b0, '0, 1'b1);
         applyStimulus(1'b0, '0, 1'b1);
      end
      runUntilDone(40, 1'b0);
      burstChecks("gap", pop_count - pop_base);
      checkOutput("gap_fifo_left", 64'(fifo_q.size()), 64'(2));
      flushFifo();

      // Zero-length burst, then a start issued mid-burst.
      $display("[TB] zero length and ignored start");
      pop_base = pop_count;
      startBurst(0, 1'b1);
      runUntilDone(10, 1'b0);
      burstChecks("zero", pop_count - pop_base);
      for (int i = 0; i < 5; i++) pushWord(BUSW'(32'h400 + i));
      pop_base = pop_count;
      startBurst(3, 1'b0);
      applyStimulus(1'b1, CNTW'(7), 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("ign_busy", 64'(busy), 64'(1));
      runUntilDone(40, 1'b0);
      burstChecks("ign", pop_count - pop_base);
      checkOutput("ign_fifo_left", 64'(fifo_q.size()), 64'(2));
      flushFifo();

      // Single-word burst.
      $display("[TB] short burst");
      pushWord(32'hA5A5_A5A5);
      pop_base = pop_count;
      startBurst(1, 1'b1);
      runUntilDone(20, 1'b0);
      burstChecks("short", pop_count - pop_base);
      checkOutput("short_checksum_value", 64'(checksum), 64'(32'hA5A5_A5A5));

      // Reset mid-burst with two words held in the output buffer.
      $display("[TB] reset mid-burst");
      for (int i = 1; i <= 8; i++) pushWord(BUSW'(32'h600 + i));
      pop_base = pop_count;
      hs_base  = hs_count;
      startBurst(6, 1'b1);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #2;
         if (hs_count >= hs_base + 3) break;
      end
      out_ready = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("mid_hs_count", 64'(hs_count - hs_base), 64'(3));
      checkOutput("mid_full_pull", 64'(pull), 64'(0));
      checkOutput("mid_full_valid", 64'(out_valid), 64'(1));
      #1;
      rst = 1'b1;
      #1;
      checkOutput("arst_pull", 64'(pull), 64'(0));
      checkOutput("arst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("arst_out_last", 64'(out_last), 64'(0));
      checkOutput("arst_busy", 64'(busy), 64'(0));
      checkOutput("arst_done", 64'(done), 64'(0));
      checkOutput("arst_words_sent", 64'(words_sent), 64'(0));
      checkOutput("arst_checksum", 64'(checksum), 64'(0));
      checkOutput("arst_pops", 64'(pop_count - pop_base), 64'(5));
      checkOutput("arst_fifo_left", 64'(fifo_q.size()), 64'(3));
      exp_q.delete();
      budget  = 0;
      avail_q = fifo_q;
      applyStimulus(1'b0, '0, 1'b1);
      rst = 1'b0;
      pop_base = pop_count;
      startBurst(2, 1'b1);
      runUntilDone(20, 1'b0);
      burstChecks("post_rst", pop_count - pop_base);
      checkOutput("post_rst_checksum_value", 64'(checksum), 64'(32'h606 ^ 32'h607));
      checkOutput("post_rst_fifo_left", 64'(fifo_q.size()), 64'(1));

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
